// File: rtl/key_sw_device_pkg.sv
// ============================================================================
// Module      : key_sw_device_pkg
// Description : Shared address map, status-bit positions and status-word
//               helpers for the KEY/SW memory-mapped input responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_sw_device_pkg;

    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    localparam int RDY_BIT = 0;
    localparam int OVR_BIT = 2;
    localparam int IE_BIT  = 8;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } status_t;

    function automatic logic [31:0] statusWord(input status_t s);
        logic [31:0] w;
        w          = '0;
        w[RDY_BIT] = s.rdy;
        w[OVR_BIT] = s.ovr;
        w[IE_BIT]  = s.ie;
        return w;
    endfunction

    // Commit is applied last so its RDY/OVR set beats a same-cycle read or clear.
    function automatic status_t statusNext(
        input status_t cur,
        input logic    commitIn,
        input logic    dataRd,
        input logic    ctrlWr,
        input logic    keepOvr,
        input logic    ieIn
    );
        status_t n;
        n = cur;
        if (ctrlWr) begin
            n.ie = ieIn;
            if (!keepOvr) n.ovr = 1'b0;
        end
        if (dataRd) n.rdy = 1'b0;
        if (commitIn) begin
            n.rdy = 1'b1;
            if (cur.rdy && !dataRd) n.ovr = 1'b1;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_sw_device_input_debouncer.sv
// ============================================================================
// Module      : input_debouncer
// Description : 2-flop synchronizer plus optional stability counter; emits the
//               committed vector and a one-cycle commit pulse.
//               Macro KEYSW_DEBOUNCE_EN enables the counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter int               CNT_BITS        = 17,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pinIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             commit
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_data;
    logic             w_diff;

    assign w_diff  = (r_sync2 != r_data);
    assign dataOut = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_data  <= RESET_VAL;
        end else begin
            r_sync1 <= pinIn;
            r_sync2 <= r_sync1;
            if (commit) r_data <= r_sync2;
        end
    end

`ifdef KEYSW_DEBOUNCE_EN
    logic [WIDTH-1:0]    r_last;
    logic [CNT_BITS-1:0] r_cnt;
    logic                w_stable;
    logic                w_done;

    // Counts cycles the synchronized vector has held still while differing
    // from the committed value; any movement of the vector restarts it.
    assign w_stable = (r_sync2 == r_last);
    assign w_done   = (r_cnt == CNT_BITS'(DEBOUNCE_CYCLES - 1));
    assign commit   = w_diff & w_stable & w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= RESET_VAL;
            r_cnt  <= '0;
        end else begin
            r_last <= r_sync2;
            if (!w_diff || !w_stable || w_done) r_cnt <= '0;
            else                                r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    localparam int c_unusedCfg = DEBOUNCE_CYCLES + CNT_BITS;

    assign commit = w_diff;
`endif

endmodule

`default_nettype wire

// File: rtl/key_sw_device.sv
// ============================================================================
// Module      : key_sw_device
// Description : Memory-mapped KEY/SW responder: address decode, sticky
//               RDY/OVR/IE status, load mux and level interrupt.
//               Macro KEYSW_DEBOUNCE_EN selects debounced commits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sw_device
    import key_sw_device_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_BITS        = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             rdEn,
    input  logic             wrEn,
    input  logic [DBITS-1:0] dataIn,
    output logic [DBITS-1:0] dataOut,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             intr
);

    logic [3:0] w_kData;
    logic [9:0] w_sData;
    logic       w_kCommit;
    logic       w_sCommit;

    input_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_BITS        (CNT_BITS),
        .RESET_VAL       (4'hF)
    ) u_keyDeb (
        .clk     (clk),
        .reset   (reset),
        .pinIn   (KEY),
        .dataOut (w_kData),
        .commit  (w_kCommit)
    );

    input_debouncer #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_BITS        (CNT_BITS),
        .RESET_VAL       (10'h000)
    ) u_swDeb (
        .clk     (clk),
        .reset   (reset),
        .pinIn   (SW),
        .dataOut (w_sData),
        .commit  (w_sCommit)
    );

    logic w_selKData, w_selSData, w_selKCtrl, w_selSCtrl;
    logic w_kDataRd, w_sDataRd, w_kCtrlWr, w_sCtrlWr;
    logic w_unusedDataIn;

    assign w_selKData = (addr == DBITS'(ADDR_KEY));
    assign w_selSData = (addr == DBITS'(ADDR_SW));
    assign w_selKCtrl = (addr == DBITS'(ADDR_KCTRL));
    assign w_selSCtrl = (addr == DBITS'(ADDR_SCTRL));

    // A simultaneous load wins; the store is dropped.
    assign w_kDataRd = rdEn & w_selKData;
    assign w_sDataRd = rdEn & w_selSData;
    assign w_kCtrlWr = wrEn & ~rdEn & w_selKCtrl;
    assign w_sCtrlWr = wrEn & ~rdEn & w_selSCtrl;

    assign w_unusedDataIn = ^{dataIn[DBITS-1:IE_BIT+1], dataIn[IE_BIT-1:OVR_BIT+1],
                              dataIn[OVR_BIT-1:0]};

    status_t r_kStat;
    status_t r_sStat;
    logic    r_intr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kStat <= '0;
            r_sStat <= '0;
            r_intr  <= 1'b0;
        end else begin
            r_kStat <= statusNext(r_kStat, w_kCommit, w_kDataRd, w_kCtrlWr,
                                  dataIn[OVR_BIT], dataIn[IE_BIT]);
            r_sStat <= statusNext(r_sStat, w_sCommit, w_sDataRd, w_sCtrlWr,
                                  dataIn[OVR_BIT], dataIn[IE_BIT]);
            r_intr  <= (r_kStat.ie & r_kStat.rdy) | (r_sStat.ie & r_sStat.rdy);
        end
    end

    assign intr = r_intr;

    always_comb begin
        dataOut = '0;
        if (w_selKData)      dataOut = DBITS'(w_kData);
        else if (w_selSData) dataOut = DBITS'(w_sData);
        else if (w_selKCtrl) dataOut = DBITS'(statusWord(r_kStat));
        else if (w_selSCtrl) dataOut = DBITS'(statusWord(r_sStat));
    end

endmodule

`default_nettype wire

// File: tb/tb_key_sw_device.sv
// ============================================================================
// Module      : tb_key_sw_device
// Description : Self-checking scoreboard bench for key_sw_device
//               (DEBOUNCE_CYCLES = 4; follows KEYSW_DEBOUNCE_EN if defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_sw_device;

    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
`ifdef KEYSW_DEBOUNCE_EN
    localparam int          LAT       = 7;
    localparam logic [31:0] BOUNCE_ST = 32'h0;
`else
    localparam int          LAT       = 3;
    localparam logic [31:0] BOUNCE_ST = 32'h5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic        intr;

    int errCnt = 0;
    int chkCnt = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];

    key_sw_device #(
        .DBITS           (32),
        .DEBOUNCE_CYCLES (4),
        .CNT_BITS        (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .rdEn    (rdEn),
        .wrEn    (wrEn),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .KEY     (KEY),
        .SW      (SW),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: drive, queue the expectation, compare at the falling edge.
    task automatic busCycle(input logic [31:0] a, input logic rd, input logic [31:0] exp,
                            input string tag);
        addr = a;
        rdEn = rd;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge clk);
        checkVal(tagQ.pop_front(), dataOut, expQ.pop_front());
        idle();
        rdEn = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        busCycle(a, 1'b0, exp, tag);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        busCycle(a, 1'b1, exp, tag);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        dataIn = d;
        wrEn   = 1'b1;
        idle();
        wrEn   = 1'b0;
    endtask

    task automatic peekIntr(input logic exp, input string tag);
        @(negedge clk);
        checkVal(tag, {31'b0, intr}, {31'b0, exp});
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; rdEn = 1'b0; wrEn = 1'b0; dataIn = '0;
        KEY = 4'hF; SW = 10'h000;
        idle(); idle();
        reset = 1'b0;

        peek(A_KDATA, 32'hF, "rst_kdata");
        peek(A_SDATA, 32'h0, "rst_sdata");
        peek(A_KCTRL, 32'h0, "rst_kctrl");
        peek(A_SCTRL, 32'h0, "rst_sctrl");
        peekIntr(1'b0, "rst_intr");
        repeat (20) idle();
        peek(A_KCTRL, 32'h0, "idle_kctrl");
        peek(A_SCTRL, 32'h0, "idle_sctrl");
        peek(32'hF000_0018, 32'h0, "unmapped");

        // Press
        KEY = 4'hE;
        repeat (LAT - 1) idle();
        peek(A_KCTRL, 32'h0, "press_early");
        peek(A_KCTRL, 32'h1, "press_rdy");
        load(A_KDATA, 32'hE, "press_kdata");
        peek(A_KCTRL, 32'h0, "press_rdclr");
        peekIntr(1'b0, "press_noie");

        // Bounce
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 10'h001 : 10'h000;
            idle(); idle();
        end
        SW = 10'h000;
        repeat (12) idle();
        peek(A_SCTRL, BOUNCE_ST, "bounce_sctrl");
        load(A_SDATA, 32'h0, "bounce_sdata");
        store(A_SCTRL, 32'h0);
        peek(A_SCTRL, 32'h0, "bounce_clean");

        // Overrun
        SW = 10'h003;
        repeat (LAT + 2) idle();
        SW = 10'h007;
        repeat (LAT + 2) idle();
        peek(A_SCTRL, 32'h5, "ovr_sctrl");
        peek(A_SDATA, 32'h7, "ovr_sdata");
        store(A_SCTRL, 32'h0);
        peek(A_SCTRL, 32'h1, "ovr_clr");
        load(A_SDATA, 32'h7, "ovr_load");
        peek(A_SCTRL, 32'h0, "ovr_rdclr");

        // Interrupt
        store(A_KCTRL, 32'h100);
        peek(A_KCTRL, 32'h100, "intr_ie");
        KEY = 4'hD;
        repeat (LAT) idle();
        peekIntr(1'b0, "intr_pre");
        peekIntr(1'b1, "intr_set");
        load(A_KDATA, 32'hD, "intr_kdata");
        peekIntr(1'b1, "intr_hold");
        peekIntr(1'b0, "intr_clr");

        // Commit racing a DATA load
        store(A_KCTRL, 32'h0);
        KEY = 4'hB;
        repeat (LAT - 1) idle();
        load(A_KDATA, 32'hD, "race_old");
        peek(A_KCTRL, 32'h1, "race_kctrl");
        peek(A_KDATA, 32'hB, "race_new");

        // Reset during a pending change
        SW = 10'h02A;
        idle(); idle();
        reset = 1'b1; SW = 10'h000; KEY = 4'hF;
        idle();
        reset = 1'b0;
        repeat (12) idle();
        peek(A_SCTRL, 32'h0, "midrst_sctrl");
        peek(A_SDATA, 32'h0, "midrst_sdata");
        peek(A_KCTRL, 32'h0, "midrst_kctrl");
        peek(A_KDATA, 32'hF, "midrst_kdata");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

`default_nettype wire
